// File: rtl/pattern_search_pkg.sv
// Shared types and constants for the pattern-count engine: state encoding,
// default memory map and the pattern width.
package pattern_search_pkg;

  localparam int unsigned PAT_ADDR_D = 32;
  localparam int unsigned OUT_ADDR_D = 33;
  localparam int unsigned N_BYTES_D  = 32;
  localparam int unsigned PW         = 5;

  typedef enum logic [2:0] {
    StLoadPat,
    StScan,
    StWrCtb,
    StWrCto,
    StWrCts,
    StDone
  } ps_state_t;

  // Population count of a 4-bit hit vector.
  function automatic logic [2:0] popcnt4(input logic [3:0] hits);
    logic [2:0] n;
    n = 3'd0;
    for (int k = 0; k < 4; k++) begin
      n = n + {2'b00, hits[k]};
    end
    return n;
  endfunction

endpackage

// File: rtl/window_match.sv
// Counts pattern matches among the four windows inside one byte and the four
// windows straddling the previous byte's low nibble and the current byte.
module window_match
  import pattern_search_pkg::*;
(
  input  logic [PW-1:0] pat,
  input  logic [3:0]    prev,
  input  logic [7:0]    cur,
  input  logic          first,
  output logic [2:0]    inbyte_cnt,
  output logic [2:0]    cross_cnt
);

  logic [11:0] w;
  logic [3:0]  in_hit;
  logic [3:0]  x_hit;

  always_comb begin
    w      = {prev, cur};
    in_hit = 4'b0000;
    x_hit  = 4'b0000;
    // k = 0 covers cur[4:0] / w[8:4]; k = 3 covers cur[7:3] / w[11:7].
    for (int k = 0; k < 4; k++) begin
      in_hit[k] = (cur[k +: PW] == pat);
      x_hit[k]  = (w[k + 4 +: PW] == pat);
    end
    inbyte_cnt = popcnt4(in_hit);
    cross_cnt  = first ? 3'd0 : popcnt4(x_hit);
  end

endmodule

// File: rtl/pattern_search_engine.sv
// Program-3 pattern-count engine: reads pattern and message from data memory,
// writes ctb/cto/cts back, then holds done until reset.
module pattern_search_engine
  import pattern_search_pkg::*;
#(
  parameter int unsigned N_BYTES  = N_BYTES_D,
  parameter int unsigned PAT_ADDR = PAT_ADDR_D,
  parameter int unsigned OUT_ADDR = OUT_ADDR_D,
  parameter int unsigned AW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rd_data,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wr_data,
  output logic          done
);

  localparam logic [AW-1:0] LastIdx = AW'(N_BYTES - 1);

  ps_state_t     state_q;
  logic [PW-1:0] pat_q;
  logic [3:0]    prev_q;
  logic [7:0]    ctb_q;
  logic [7:0]    cto_q;
  logic [7:0]    cts_q;
  logic [AW-1:0] idx_q;
  logic          done_q;

  logic [2:0] inbyte_cnt;
  logic [2:0] cross_cnt;

  window_match u_window_match (
    .pat        (pat_q),
    .prev       (prev_q),
    .cur        (mem_rd_data),
    .first      (idx_q == '0),
    .inbyte_cnt (inbyte_cnt),
    .cross_cnt  (cross_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StLoadPat;
      pat_q   <= '0;
      prev_q  <= '0;
      ctb_q   <= '0;
      cto_q   <= '0;
      cts_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        StLoadPat: begin
          pat_q   <= mem_rd_data[7:3];
          state_q <= StScan;
        end
        StScan: begin
          ctb_q  <= ctb_q + {5'd0, inbyte_cnt};
          cto_q  <= cto_q + {7'd0, |inbyte_cnt};
          cts_q  <= cts_q + {5'd0, inbyte_cnt} + {5'd0, cross_cnt};
          prev_q <= mem_rd_data[3:0];
          if (idx_q == LastIdx) begin
            state_q <= StWrCtb;
          end else begin
            idx_q <= idx_q + AW'(1);
          end
        end
        StWrCtb: state_q <= StWrCto;
        StWrCto: state_q <= StWrCts;
        StWrCts: begin
          state_q <= StDone;
          done_q  <= 1'b1;
        end
        StDone:  state_q <= StDone;
        default: state_q <= StLoadPat;
      endcase
    end
  end

  // Writes are gated by reset so an abort never commits a partial result.
  always_comb begin
    mem_addr    = AW'(PAT_ADDR);
    mem_wr_en   = 1'b0;
    mem_wr_data = 8'd0;
    case (state_q)
      StScan: mem_addr = idx_q;
      StWrCtb: begin
        mem_addr    = AW'(OUT_ADDR);
        mem_wr_en   = ~reset;
        mem_wr_data = ctb_q;
      end
      StWrCto: begin
        mem_addr    = AW'(OUT_ADDR + 1);
        mem_wr_en   = ~reset;
        mem_wr_data = cto_q;
      end
      StWrCts: begin
        mem_addr    = AW'(OUT_ADDR + 2);
        mem_wr_en   = ~reset;
        mem_wr_data = cts_q;
      end
      default: ;
    endcase
  end

  assign done = done_q;

endmodule

// File: tb/tb_pattern_search_engine.sv
// Scoreboard bench for pattern_search_engine: expected writes are queued per
// run and a negedge monitor checks each write the engine issues.
module tb_pattern_search_engine;

  typedef struct {
    int addr;
    int data;
    int edge_no;
  } wr_t;

  logic       clk;
  logic       reset;
  logic [7:0] mem_addr;
  logic [7:0] mem_rd_data;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;
  logic       done;

  logic [7:0] mem [256];
  logic [7:0] msg [32];
  logic [7:0] pat_byte;
  logic       fill_en;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks;
  int  errors;
  int  edge_cnt;
  int  wr_count;

  pattern_search_engine dut (
    .clk         (clk),
    .reset       (reset),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rd_data = mem[mem_addr];

  always @(posedge clk) begin
    if (fill_en) begin
      for (int i = 0; i < 32; i++) mem[i] <= msg[i];
      mem[32] <= pat_byte;
      mem[33] <= 8'hEE;
      mem[34] <= 8'hEE;
      mem[35] <= 8'hEE;
    end else if (mem_wr_en) begin
      mem[mem_addr] <= mem_wr_data;
    end
  end

  // Edge 1 is the first rising edge that samples reset low.
  always @(posedge clk) begin
    if (reset) edge_cnt <= 0;
    else       edge_cnt <= edge_cnt + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // A write seen at a negedge commits on the following rising edge.
  always @(negedge clk) begin
    if (mem_wr_en) begin
      wr_count++;
      if (reset) begin
        chk("write_during_reset", 1, 0);
      end else if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", int'(mem_addr), -1);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", int'(mem_addr), mon_e.addr);
        chk("wr_data", int'(mem_wr_data), mon_e.data);
        chk("wr_edge", edge_cnt + 1, mon_e.edge_no);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic fill_msg(input logic [7:0] b);
    for (int i = 0; i < 32; i++) msg[i] = b;
  endtask

  task automatic run(input string tag, input logic [4:0] p, input int ectb, input int ecto,
                     input int ects, input bit pulse);
    int n;
    reset    = 1'b1;
    pat_byte = {p, 3'b101};
    fill_en  = 1'b1;
    step();
    fill_en  = 1'b0;
    step();
    exp_q.delete();
    exp_q.push_back('{addr: 33, data: ectb, edge_no: 34});
    exp_q.push_back('{addr: 34, data: ecto, edge_no: 35});
    exp_q.push_back('{addr: 35, data: ects, edge_no: 36});
    wr_count = 0;
    reset = 1'b0;
    if (pulse) begin
      repeat (9) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
    end
    n = 0;
    while (!done && n < 200) begin
      step();
      n++;
    end
    if (!done) begin
      chk({tag, "_done_timeout"}, 0, 1);
    end else begin
      chk({tag, "_done_edge"}, edge_cnt, 36);
    end
    chk({tag, "_writes_pending"}, exp_q.size(), 0);
    chk({tag, "_write_count"}, wr_count, 3);
    chk({tag, "_mem_ctb"}, int'(mem[33]), ectb);
    chk({tag, "_mem_cto"}, int'(mem[34]), ecto);
    chk({tag, "_mem_cts"}, int'(mem[35]), ects);
    chk({tag, "_done_addr"}, int'(mem_addr), 32);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    wr_count = 0;
    reset    = 1'b1;
    fill_en  = 1'b0;
    pat_byte = 8'h00;
    fill_msg(8'h00);
    repeat (3) step();
    chk("rst_done", int'(done), 0);
    chk("rst_wr_en", int'(mem_wr_en), 0);
    chk("rst_addr", int'(mem_addr), 32);

    fill_msg(8'h00);
    run("zeros_p00", 5'b00000, 128, 32, 252, 1'b0);

    fill_msg(8'h55);
    run("x55_p15", 5'b10101, 64, 32, 126, 1'b0);

    fill_msg(8'h00);
    run("zeros_p1f", 5'b11111, 0, 0, 0, 1'b0);

    fill_msg(8'h00);
    msg[0] = 8'h07;
    msg[1] = 8'hC0;
    run("cross_only", 5'b11111, 0, 0, 1, 1'b0);

    fill_msg(8'h55);
    run("reset_pulse", 5'b10101, 64, 32, 126, 1'b1);

    wr_count = 0;
    repeat (20) begin
      step();
      chk("hold_done", int'(done), 1);
      chk("hold_wr_en", int'(mem_wr_en), 0);
    end
    chk("hold_write_count", wr_count, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("done_drop", int'(done), 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
